// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg
//   Shared types and constants for the AHB-to-APB bridge master arbiter.
//   - arb_state_t  : arbiter sequencing states
//   - TRANS_IDLE   : H_TRANS encoding for no transfer
//   - TRANS_ACTIVE : H_TRANS encoding driven during the address phase
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_ADDR = 3'd1,
    ARB_DATA = 3'd2,
    ARB_DONE = 3'd3,
    ARB_ERR  = 3'd4
  } arb_state_t;

  localparam logic [2:0] TRANS_IDLE   = 3'b000;
  localparam logic [2:0] TRANS_ACTIVE = 3'b011;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin pick: returns the first asserted request at or
//   after ptr, wrapping around modulo N. Reusable by any requester arbiter.
// Ports
//   req    in  N   request vector
//   ptr    in  IW  highest-priority position this round
//   onehot out N   one-hot winner (zero when no request)
//   index  out IW  winner index (zero when no request)
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;
  logic          found;

  // Walk the requesters starting at ptr; the first hit wins and later hits
  // are masked off by 'found'.
  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/apb_bridge_master_arbiter.sv
// apb_bridge_master_arbiter
//   Round-robin arbiter/sequencer sharing one AHB-to-APB bridge between
//   NUM_MASTERS requesters. Grants one master, runs one address phase and a
//   data phase on the bridge's AHB side, then pulses M_DONE (or M_ERR on
//   timeout) to the owner. All outputs are registered.
// Ports
//   H_CLK, H_RESET          clock / synchronous active-high reset
//   M_REQ, M_WRITE          per-master request and direction
//   M_ADDR, M_WDATA         per-master address / write data, packed by index
//   M_GNT, M_DONE, M_ERR    one-hot grant, completion pulse, timeout pulse
//   M_RDATA                 read data, valid in the M_DONE cycle of a read
//   H_READY, H_RDATA        from the bridge
//   H_SEL_APB, H_TRANS, H_WRITE, H_ADDR, H_WDATA   to the bridge
module apb_bridge_master_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TRAN_WIDTH  = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                              H_CLK,
  input  logic                              H_RESET,
  input  logic [NUM_MASTERS-1:0]            M_REQ,
  input  logic [NUM_MASTERS-1:0]            M_WRITE,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_ADDR,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_WDATA,
  output logic [NUM_MASTERS-1:0]            M_GNT,
  output logic [NUM_MASTERS-1:0]            M_DONE,
  output logic [NUM_MASTERS-1:0]            M_ERR,
  output logic [DATA_WIDTH-1:0]             M_RDATA,
  input  logic                              H_READY,
  input  logic [DATA_WIDTH-1:0]             H_RDATA,
  output logic                              H_SEL_APB,
  output logic [TRAN_WIDTH-1:0]             H_TRANS,
  output logic                              H_WRITE,
  output logic [ADDR_WIDTH-1:0]             H_ADDR,
  output logic [DATA_WIDTH-1:0]             H_WDATA
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  arb_state_t             state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          owner;
  logic [IW-1:0]          next_ptr;
  logic [CW-1:0]          data_cnt;
  logic [CW-1:0]          cnt_next;
  logic [DATA_WIDTH-1:0]  lat_wdata;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req    (M_REQ),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  // Rotation always restarts just past the last owner, whether it finished
  // or timed out, so no requester waits more than NUM_MASTERS-1 transfers.
  assign next_ptr = (owner == IW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
  assign cnt_next = data_cnt + 1'b1;

  always_ff @(posedge H_CLK) begin
    if (H_RESET) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      data_cnt  <= '0;
      lat_wdata <= '0;
      M_GNT     <= '0;
      M_DONE    <= '0;
      M_ERR     <= '0;
      M_RDATA   <= '0;
      H_SEL_APB <= 1'b0;
      H_TRANS   <= TRAN_WIDTH'(TRANS_IDLE);
      H_WRITE   <= 1'b0;
      H_ADDR    <= '0;
      H_WDATA   <= '0;
    end else begin
      // Completion and error are single-cycle pulses.
      M_DONE <= '0;
      M_ERR  <= '0;
      case (state)
        ARB_IDLE: begin
          // Master inputs are captured here only; later changes are ignored.
          if (|M_REQ && H_READY) begin
            state     <= ARB_ADDR;
            owner     <= pick_idx;
            M_GNT     <= pick_onehot;
            H_SEL_APB <= 1'b1;
            H_TRANS   <= TRAN_WIDTH'(TRANS_ACTIVE);
            H_WRITE   <= M_WRITE[pick_idx];
            H_ADDR    <= M_ADDR[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= M_WDATA[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ARB_ADDR: begin
          state     <= ARB_DATA;
          H_SEL_APB <= 1'b0;
          H_TRANS   <= TRAN_WIDTH'(TRANS_IDLE);
          H_WDATA   <= lat_wdata;
          data_cnt  <= '0;
        end
        ARB_DATA: begin
          // data_cnt==0 is the first data cycle, where the bridge is still
          // dropping H_READY, so its value there is ignored. A ready in the
          // last allowed cycle wins over the timeout.
          if (data_cnt != '0 && H_READY) begin
            state  <= ARB_DONE;
            M_DONE <= M_GNT;
            M_GNT  <= '0;
            rr_ptr <= next_ptr;
            if (!H_WRITE) begin
              M_RDATA <= H_RDATA;
            end
          end else if (cnt_next == CNT_LIMIT) begin
            state  <= ARB_ERR;
            M_ERR  <= M_GNT;
            M_GNT  <= '0;
            rr_ptr <= next_ptr;
          end else begin
            data_cnt <= cnt_next;
          end
        end
        ARB_DONE, ARB_ERR: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
